// File: rtl/hazard_pkg.sv
// Shared types for the pipeline stall/flush controller:
// FSM state enum, strobe bundle and canned strobe patterns.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    ERR   = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_clr;
    logic idex_clr;
    logic exmem_clr;
    logic memwb_clr;
  } stage_ctrl_t;

  localparam stage_ctrl_t STROBE_DEFAULT =
    stage_ctrl_t'(9'b11111_0000);
  localparam stage_ctrl_t STROBE_STALL =
    stage_ctrl_t'(9'b00000_0001);
  localparam stage_ctrl_t STROBE_RESET =
    stage_ctrl_t'(9'b00000_1111);
  localparam stage_ctrl_t STROBE_FREEZE =
    stage_ctrl_t'(9'b00000_0000);

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait FSM: RUN / MWAIT / ERR with saturating wait counter.
// Ports: clk, rst, mem_req_i, mem_ack_i -> state_o, mem_err_o (sticky).
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      mem_req_i,
  input  logic      mem_ack_i,
  output hz_state_e state_o,
  output logic      mem_err_o
);

  localparam int CW =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (MEM_TIMEOUT != 0);
  localparam logic [CW-1:0] TMO_CNT = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  hz_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_req_i && !mem_ack_i) begin
            state_q <= MWAIT;
            cnt_q   <= CW'(1);
          end
        end
        MWAIT: begin
          if (mem_ack_i || !mem_req_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else if (TMO_EN && cnt_q == TMO_CNT) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ERR: begin
          err_q <= 1'b1;
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign state_o   = state_q;
  assign mem_err_o = err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: load-use, branch flush, memory wait + timeout.
// Ports: hazard inputs -> *_we/*_clr strobes, mem_err; perf counters
// stall_cycles/flush_count only when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_memread,
  input  logic       ex_regwrite,
  input  logic [4:0] ex_wregnum,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ack,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       idex_we,
  output logic       exmem_we,
  output logic       memwb_we,
  output logic       ifid_clr,
  output logic       idex_clr,
  output logic       exmem_clr,
  output logic       memwb_clr,
  output logic       mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  hz_state_e   state;
  stage_ctrl_t ctrl;
  logic        luse;
  logic        mstall;

  mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .mem_req_i(mem_req),
    .mem_ack_i(mem_ack),
    .state_o  (state),
    .mem_err_o(mem_err)
  );

  assign luse = ex_memread && ex_regwrite &&
                (ex_wregnum != 5'd0) &&
                (ex_wregnum == id_rs ||
                 ex_wregnum == id_rt);

  assign mstall = mem_req && !mem_ack;

  always_comb begin
    ctrl = STROBE_DEFAULT;
    if (rst) begin
      ctrl = STROBE_RESET;
    end else begin
      unique case (state)
        RUN: begin
          if (mstall) begin
            ctrl = STROBE_STALL;
          end else if (ex_branch_taken) begin
            // ID instr is squashed, so luse needs no stall
            ctrl.ifid_clr = 1'b1;
            ctrl.idex_clr = 1'b1;
          end else if (luse) begin
            ctrl.pc_we    = 1'b0;
            ctrl.ifid_we  = 1'b0;
            ctrl.idex_clr = 1'b1;
          end
        end
        // timeout cycle also stalls; only ack or withdraw resume
        MWAIT: begin
          if (mstall) ctrl = STROBE_STALL;
        end
        ERR: begin
          ctrl = STROBE_FREEZE;
        end
        default: begin
          ctrl = STROBE_RESET;
        end
      endcase
    end
  end

  assign pc_we     = ctrl.pc_we;
  assign ifid_we   = ctrl.ifid_we;
  assign idex_we   = ctrl.idex_we;
  assign exmem_we  = ctrl.exmem_we;
  assign memwb_we  = ctrl.memwb_we;
  assign ifid_clr  = ctrl.ifid_clr;
  assign idex_clr  = ctrl.idex_clr;
  assign exmem_clr = ctrl.exmem_clr;
  assign memwb_clr = ctrl.memwb_clr;

`ifdef HAZARD_PERF_EN
  logic        flush_apply;
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  assign flush_apply = (state == RUN) && !mstall &&
                       ex_branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ctrl.pc_we && state != ERR)
        stall_q <= stall_q + 32'd1;
      if (flush_apply)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4),
// directed hazard scenarios followed by randomized stimulus.
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 4;

  localparam logic [8:0] E_DEF = 9'b11111_0000;
  localparam logic [8:0] E_STL = 9'b00000_0001;
  localparam logic [8:0] E_RST = 9'b00000_1111;
  localparam logic [8:0] E_BR  = 9'b11111_1100;
  localparam logic [8:0] E_LU  = 9'b00111_0100;
  localparam logic [8:0] E_FRZ = 9'b00000_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       ex_memread = 1'b0;
  logic       ex_regwrite = 1'b0;
  logic [4:0] ex_wregnum = '0;
  logic       ex_branch_taken = 1'b0;
  logic       mem_req = 1'b0;
  logic       mem_ack = 1'b0;
  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic ifid_clr, idex_clr, exmem_clr, memwb_clr;
  logic mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .ex_memread     (ex_memread),
    .ex_regwrite    (ex_regwrite),
    .ex_wregnum     (ex_wregnum),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .pc_we          (pc_we),
    .ifid_we        (ifid_we),
    .idex_we        (idex_we),
    .exmem_we       (exmem_we),
    .memwb_we       (memwb_we),
    .ifid_clr       (ifid_clr),
    .idex_clr       (idex_clr),
    .exmem_clr      (exmem_clr),
    .memwb_clr      (memwb_clr),
    .mem_err        (mem_err)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: pipeline mode and wait length as plain ints
  bit          m_err  = 1'b0;
  bit          m_wait = 1'b0;
  int          m_n    = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] obs();
    return {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
            ifid_clr, idex_clr, exmem_clr, memwb_clr};
  endfunction

  task automatic model_reset();
    m_err   = 1'b0;
    m_wait  = 1'b0;
    m_n     = 0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // one clock cycle: check at negedge, advance model at posedge
  task automatic tick(input string tag);
    logic [8:0] e;
    bit luse, mst, fl, nerr, nwait;
    int nn;
    @(negedge clk);
    luse = ex_memread && ex_regwrite && ex_wregnum != 0 &&
           (ex_wregnum == id_rs || ex_wregnum == id_rt);
    mst  = mem_req && !mem_ack;
    fl   = 1'b0;
    nerr = m_err; nwait = m_wait; nn = m_n;
    if (rst) e = E_RST;
    else if (m_err) e = E_FRZ;
    else if (m_wait) begin
      if (!mst) begin
        e = E_DEF; nwait = 1'b0;
      end else begin
        e = E_STL;
        if (TMO != 0 && m_n == TMO) begin
          nerr = 1'b1; nwait = 1'b0;
        end else nn = m_n + 1;
      end
    end else if (mst) begin
      e = E_STL; nwait = 1'b1; nn = 1;
    end else if (ex_branch_taken) begin
      e = E_BR; fl = 1'b1;
    end else if (luse) e = E_LU;
    else e = E_DEF;
    chk({tag, ".strobes"}, 32'(obs()), 32'(e));
    chk({tag, ".mem_err"}, 32'(mem_err),
        32'(m_err && !rst));
`ifdef HAZARD_PERF_EN
    chk({tag, ".stall_cycles"}, stall_cycles, m_stall);
    chk({tag, ".flush_count"}, flush_count, m_flush);
`endif
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (!e[8] && !m_err) m_stall++;
      if (fl) m_flush++;
      m_err = nerr; m_wait = nwait; m_n = nn;
    end
    #1;
  endtask

  task automatic idle();
    ex_memread = 0; ex_regwrite = 0; ex_wregnum = 0;
    id_rs = 0; id_rt = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ack = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick("reset");
    tick("reset");
    rst = 1'b0;
  endtask

  initial begin
    idle();
    model_reset();
    #1;
    do_reset();
    tick("idle");

    // load-use on rt
    ex_memread = 1; ex_regwrite = 1;
    ex_wregnum = 5'd5; id_rt = 5'd5; id_rs = 5'd3;
    tick("luse_rt");
    ex_wregnum = 5'd0; id_rt = 5'd0;
    tick("luse_r0");
    // branch masks load-use
    ex_wregnum = 5'd7; id_rs = 5'd7; ex_branch_taken = 1;
    tick("br_luse");
    idle();

    // ack after 3 stall cycles
    mem_req = 1;
    repeat (3) tick("mwait3");
    mem_ack = 1;
    tick("mack");
    idle();
    tick("post_ack");
`ifdef HAZARD_PERF_EN
    chk("perf_stall4", stall_cycles, 32'd4);
`endif
    ex_branch_taken = 1;
    tick("br2");
    idle();
`ifdef HAZARD_PERF_EN
    chk("perf_flush2", flush_count, 32'd2);
`endif

    // single-cycle memory
    mem_req = 1; mem_ack = 1;
    tick("mem_1cyc");
    idle();

    // withdrawn request
    mem_req = 1;
    tick("wd_stall");
    mem_req = 0;
    tick("wd_resume");

    // timeout into ERR, held until reset
    mem_req = 1;
    repeat (7) tick("tmo");
    idle();
    repeat (2) tick("err_hold");
    do_reset();
    tick("err_clr");

    // async reset in the middle of MWAIT
    mem_req = 1;
    repeat (2) tick("pre_async");
    #2 rst = 1'b1;
    #1;
    chk("async.strobes", 32'(obs()), 32'(E_RST));
    chk("async.mem_err", 32'(mem_err), 32'd0);
    model_reset();
    tick("async_hold");
    rst = 1'b0;
    idle();
    tick("async_run");

    // randomized
    for (int i = 0; i < 1500; i++) begin
      rst = (m_err && $urandom_range(3) == 0) ||
            ($urandom_range(99) == 0);
      mem_req = ($urandom_range(9) < 3);
      mem_ack = $urandom_range(1);
      ex_branch_taken = ($urandom_range(4) == 0);
      ex_memread  = ($urandom_range(4) < 2);
      ex_regwrite = ($urandom_range(9) < 7);
      ex_wregnum  = 5'($urandom_range(7));
      id_rs       = 5'($urandom_range(7));
      id_rt       = 5'($urandom_range(7));
      tick("rand");
    end
    rst = 1'b0;
    idle();
    tick("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
